// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM duty meter.
//   state_e          : measurement FSM states
//   PWM_SLOTS        : period of the 10-slot PWM generator, in clk cycles
//   CNT_W_DEFAULT    : default result/counter width
//   TIMEOUT_DEFAULT  : default stuck-input timeout, in clk cycles
package pwm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RISE,
    HIGH,
    LOW
  } state_e;

  localparam int unsigned PWM_SLOTS       = 10;
  localparam int unsigned CNT_W_DEFAULT   = 16;
  localparam int unsigned TIMEOUT_DEFAULT = 1000;

endpackage

// File: rtl/pwm_duty_meter_sync_edge.sv
// Two-flop synchronizer plus history flop for an asynchronous input,
// with single-cycle rise/fall strobes.
//   clk, rst_n  : clock, asynchronous active-low reset
//   async_in    : raw input, may be asynchronous to clk
//   sync_level  : synchronized level (s2)
//   rise, fall  : s2 & ~s3, ~s2 & s3
module pwm_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_level,
  output logic rise,
  output logic fall
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic s3_q, s3_d;

  always_comb begin
    s1_d = async_in;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign sync_level = s2_q;
  assign rise       = s2_q & ~s3_q;
  assign fall       = ~s2_q & s3_q;

endmodule

// File: rtl/pwm_duty_meter.sv
// PWM duty meter: measures high time and period (clk cycles) of pwm_in once
// per full period, flags a stuck input after TIMEOUT cycles without an edge,
// and presents each result on a valid/ready interface.
//   clk, rst_n          : clock, asynchronous active-low reset
//   pwm_in              : PWM input (asynchronous)
//   meas_en             : 1 = measure, 0 = idle and clear overrun
//   high_cnt/period_cnt : result fields (period_cnt = 0 for a stuck result)
//   stuck, stuck_level  : timeout result flag and synchronized level at timeout
//   meas_valid/ready    : result handshake
//   overrun             : sticky, a result was dropped
module pwm_duty_meter
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W   = CNT_W_DEFAULT,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  input  logic             meas_en,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic             stuck,
  output logic             stuck_level,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic             overrun
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(TIMEOUT - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_ONE;
  endfunction

  logic sync_level, rise, fall;

  pwm_sync_edge u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .async_in  (pwm_in),
    .sync_level(sync_level),
    .rise      (rise),
    .fall      (fall)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic [CNT_W-1:0] gap_q, gap_d;

  logic             valid_q, valid_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             stuck_q, stuck_d;
  logic             level_q, level_d;
  logic             overrun_q, overrun_d;

  logic             publish;
  logic [CNT_W-1:0] pub_high, pub_period;
  logic             pub_stuck, pub_level;

  // Measurement FSM and counters.
  always_comb begin
    state_d    = state_q;
    hcnt_d     = hcnt_q;
    pcnt_d     = pcnt_q;
    gap_d      = gap_q;
    publish    = 1'b0;
    pub_high   = '0;
    pub_period = '0;
    pub_stuck  = 1'b0;
    pub_level  = 1'b0;

    if (!meas_en) begin
      state_d = IDLE;
      hcnt_d  = '0;
      pcnt_d  = '0;
      gap_d   = '0;
    end else begin
      gap_d = (rise | fall) ? '0 : gap_q + CNT_ONE;

      unique case (state_q)
        IDLE: begin
          state_d = WAIT_RISE;
          hcnt_d  = '0;
          pcnt_d  = '0;
          gap_d   = '0;
        end
        WAIT_RISE: begin
          if (rise) begin
            hcnt_d  = CNT_ONE;
            pcnt_d  = CNT_ONE;
            state_d = HIGH;
          end
        end
        HIGH: begin
          pcnt_d = sat_inc(pcnt_q);
          if (fall) state_d = LOW;
          else      hcnt_d  = sat_inc(hcnt_q);
        end
        LOW: begin
          if (rise) begin
            publish    = 1'b1;
            pub_high   = hcnt_q;
            pub_period = pcnt_q;
            hcnt_d     = CNT_ONE;
            pcnt_d     = CNT_ONE;
            state_d    = HIGH;
          end else begin
            pcnt_d = sat_inc(pcnt_q);
          end
        end
      endcase

      // Any edge in this cycle means the input is toggling, so it takes
      // precedence over an expiring gap counter.
      if (state_q != IDLE && !(rise | fall) && gap_q == GAP_LAST) begin
        publish    = 1'b1;
        pub_stuck  = 1'b1;
        pub_level  = sync_level;
        pub_high   = sync_level ? '1 : '0;
        pub_period = '0;
        state_d    = WAIT_RISE;
        hcnt_d     = '0;
        pcnt_d     = '0;
        gap_d      = '0;
      end
    end
  end

  // Result register and handshake. A publish that meets a held result
  // is dropped in favour of the older one.
  always_comb begin
    valid_d   = valid_q;
    high_d    = high_q;
    period_d  = period_q;
    stuck_d   = stuck_q;
    level_d   = level_q;
    overrun_d = overrun_q;

    if (publish) begin
      if (!valid_q || meas_ready) begin
        valid_d  = 1'b1;
        high_d   = pub_high;
        period_d = pub_period;
        stuck_d  = pub_stuck;
        level_d  = pub_level;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && meas_ready) begin
      valid_d = 1'b0;
    end

    if (!meas_en) overrun_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      hcnt_q    <= '0;
      pcnt_q    <= '0;
      gap_q     <= '0;
      valid_q   <= 1'b0;
      high_q    <= '0;
      period_q  <= '0;
      stuck_q   <= 1'b0;
      level_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hcnt_q    <= hcnt_d;
      pcnt_q    <= pcnt_d;
      gap_q     <= gap_d;
      valid_q   <= valid_d;
      high_q    <= high_d;
      period_q  <= period_d;
      stuck_q   <= stuck_d;
      level_q   <= level_d;
      overrun_q <= overrun_d;
    end
  end

  assign high_cnt    = high_q;
  assign period_cnt  = period_q;
  assign stuck       = stuck_q;
  assign stuck_level = level_q;
  assign meas_valid  = valid_q;
  assign overrun     = overrun_q;

endmodule
